memory_access_unit: RTL and testbench

MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

---
 rtl/memory_access_unit_if.sv | 22 ++
 rtl/memory_access_unit.sv | 132 +++++++++++++
 tb/tb_memory_access_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_unit_if.sv
// Data-memory bus between the memory stage and the data memory.
// The master issues word-aligned requests; the slave grants and responds.
interface memory_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/memory_access_unit.sv
// Memory stage: load/store sequencing, lane steering and extension.
// Optional MISALIGN_TRAP_EN flags misaligned H/W accesses instead of aligning them.
module memory_access_unit (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 M_alu_result,
  input  logic [31:0]                 M_write_data,
  input  logic                        M_mem_read,
  input  logic                        M_mem_write,
  input  logic [2:0]                  M_funct3,
  output logic [31:0]                 M_read_data,
  output logic                        M_mem_stall,
  output logic                        M_misaligned,
  memory_access_unit_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RESP,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] rdata_q;
  logic        ld_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;

  logic        op_valid;
  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic [1:0]  lane;
  logic        misalign;
  logic        issue;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [31:0] sh;
  logic [31:0] ext;

  assign op_valid = M_mem_read | M_mem_write;
  assign is_b     = (M_funct3[1:0] == 2'b00);
  assign is_h     = (M_funct3[1:0] == 2'b01);
  assign is_w     = M_funct3[1];

`ifdef MISALIGN_TRAP_EN
  assign lane     = M_alu_result[1:0];
  assign misalign = (is_h & M_alu_result[0]) |
                    (is_w & (|M_alu_result[1:0]));
`else
  // Without the trap, sub-word offsets are forced to natural alignment.
  assign lane     = is_w ? 2'b00 :
                    is_h ? {M_alu_result[1], 1'b0} :
                    M_alu_result[1:0];
  assign misalign = 1'b0;
`endif

  assign issue = rst_n & (state == IDLE) & op_valid & ~misalign;

  always_comb begin
    strb  = 4'b1111;
    wdata = M_write_data;
    unique case (1'b1)
      is_b: begin
        strb  = 4'b0001 << lane;
        wdata = {4{M_write_data[7:0]}};
      end
      is_h: begin
        strb  = 4'b0011 << lane;
        wdata = {2{M_write_data[15:0]}};
      end
      default: begin
        strb  = 4'b1111;
        wdata = M_write_data;
      end
    endcase
  end

  assign bus.dmem_req   = issue;
  assign bus.dmem_we    = issue & ~M_mem_read;
  assign bus.dmem_addr  = {M_alu_result[31:2], 2'b00};
  assign bus.dmem_wdata = wdata;
  assign bus.dmem_wstrb = (issue & ~M_mem_read) ? strb : 4'b0000;

  assign M_mem_stall  = rst_n & (issue | (state == WAIT_RESP));
  assign M_misaligned = rst_n & (state == IDLE) & op_valid & misalign;
  assign M_read_data  = (state == DONE) ? rdata_q : 32'h0;

  assign sh = bus.dmem_rdata >> {lane_q, 3'b000};

  always_comb begin
    ext = bus.dmem_rdata;
    unique case (1'b1)
      f3_q[1]:
        ext = bus.dmem_rdata;
      (f3_q[1:0] == 2'b01):
        ext = {{16{~f3_q[2] & sh[15]}}, sh[15:0]};
      default:
        ext = {{24{~f3_q[2] & sh[7]}}, sh[7:0]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rdata_q <= 32'h0;
      ld_q    <= 1'b0;
      f3_q    <= 3'b000;
      lane_q  <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (issue && bus.dmem_gnt) begin
            state  <= WAIT_RESP;
            ld_q   <= M_mem_read;
            f3_q   <= M_funct3;
            lane_q <= lane;
          end
        end
        WAIT_RESP: begin
          if (bus.dmem_rvalid) begin
            state   <= DONE;
            rdata_q <= ld_q ? ext : 32'h0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit: directed vectors push per-cycle
// expectations; a negedge monitor pops and compares.
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] M_alu_result;
  logic [31:0] M_write_data;
  logic        M_mem_read;
  logic        M_mem_write;
  logic [2:0]  M_funct3;
  logic [31:0] M_read_data;
  logic        M_mem_stall;
  logic        M_misaligned;

  memory_access_unit_if bus ();

  memory_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .M_alu_result (M_alu_result),
    .M_write_data (M_write_data),
    .M_mem_read   (M_mem_read),
    .M_mem_write  (M_mem_write),
    .M_funct3     (M_funct3),
    .M_read_data  (M_read_data),
    .M_mem_stall  (M_mem_stall),
    .M_misaligned (M_misaligned),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        req;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        mis;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h", n, act, exp);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.name, ".req"}, 32'(bus.dmem_req), 32'(e.req));
      chk({e.name, ".stall"}, 32'(M_mem_stall), 32'(e.stall));
      chk({e.name, ".mis"}, 32'(M_misaligned), 32'(e.mis));
      chk({e.name, ".rdata"}, M_read_data, e.rd);
      if (e.req) begin
        chk({e.name, ".we"}, 32'(bus.dmem_we), 32'(e.we));
        chk({e.name, ".wstrb"}, 32'(bus.dmem_wstrb), 32'(e.wstrb));
        chk({e.name, ".addr"}, bus.dmem_addr, e.addr);
        if (e.we)
          chk({e.name, ".wdata"}, bus.dmem_wdata, e.wdata);
      end
    end
  end

  task automatic step(
    input string n, input logic rst, rd, wr,
    input logic [2:0] f3, input logic [31:0] a, d,
    input logic gnt, rv, input logic [31:0] rdat,
    input logic ereq, ewe, input logic [3:0] estrb,
    input logic [31:0] eaddr, ewdata,
    input logic estall, emis, input logic [31:0] erd);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n           = rst;
    M_mem_read      = rd;
    M_mem_write     = wr;
    M_funct3        = f3;
    M_alu_result    = a;
    M_write_data    = d;
    bus.dmem_gnt    = gnt;
    bus.dmem_rvalid = rv;
    bus.dmem_rdata  = rdat;
    e.name  = n;
    e.req   = ereq;
    e.we    = ewe;
    e.wstrb = estrb;
    e.addr  = eaddr;
    e.wdata = ewdata;
    e.stall = estall;
    e.mis   = emis;
    e.rd    = erd;
    sb.push_back(e);
  endtask

  task automatic idle(input string n, input logic rv,
                      input logic [31:0] rdat);
    step(n, 1, 0, 0, 3'b000, 0, 0, 1, rv, rdat,
         0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic load(input string n, input logic wr,
                      input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] rdat, eaddr, erd);
    step({n, "_c0"}, 1, 1, wr, f3, a, 0, 1, 0, 0,
         1, 0, 4'b0000, eaddr, 0, 1, 0, 32'h0);
    step({n, "_c1"}, 1, 1, wr, f3, a, 0, 0, 1, rdat,
         0, 0, 0, 0, 0, 1, 0, 32'h0);
    step({n, "_c2"}, 1, 0, 0, f3, a, 0, 0, 0, 0,
         0, 0, 0, 0, 0, 0, 0, erd);
  endtask

  task automatic store(input string n, input logic [2:0] f3,
                       input logic [31:0] a, d, eaddr, ewdata,
                       input logic [3:0] estrb);
    step({n, "_c0"}, 1, 0, 1, f3, a, d, 1, 0, 0,
         1, 1, estrb, eaddr, ewdata, 1, 0, 32'h0);
    step({n, "_c1"}, 1, 0, 1, f3, a, d, 0, 1, 32'hDEADBEEF,
         0, 0, 0, 0, 0, 1, 0, 32'h0);
    step({n, "_c2"}, 1, 0, 0, f3, a, d, 0, 0, 0,
         0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    rst_n           = 1'b0;
    M_mem_read      = 1'b1;
    M_mem_write     = 1'b0;
    M_funct3        = 3'b000;
    M_alu_result    = 32'h1003;
    M_write_data    = 32'h0;
    bus.dmem_gnt    = 1'b1;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = 32'h0;

    // Reset held with a live op: bus and flags must stay quiet.
    step("rst0", 0, 1, 0, 3'b000, 32'h1003, 0, 1, 0, 0,
         0, 0, 0, 0, 0, 0, 0, 32'h0);
    step("rst1", 0, 1, 0, 3'b000, 32'h1003, 0, 1, 0, 0,
         0, 0, 0, 0, 0, 0, 0, 32'h0);

    load("lb", 0, 3'b000, 32'h1003, 32'h80FF_FF00,
         32'h1000, 32'hFFFF_FF80);
    idle("idle0", 0, 0);

    // SH with a one-cycle grant delay and a late acknowledge.
    step("sh_c0", 1, 0, 1, 3'b001, 32'h2002, 32'h0000_BEEF, 0, 0, 0,
         1, 1, 4'b1100, 32'h2000, 32'hBEEF_BEEF, 1, 0, 32'h0);
    step("sh_c1", 1, 0, 1, 3'b001, 32'h2002, 32'h0000_BEEF, 1, 0, 0,
         1, 1, 4'b1100, 32'h2000, 32'hBEEF_BEEF, 1, 0, 32'h0);
    step("sh_c2", 1, 0, 1, 3'b001, 32'h2002, 32'h0000_BEEF, 0, 0, 0,
         0, 0, 0, 0, 0, 1, 0, 32'h0);
    step("sh_c3", 1, 0, 1, 3'b001, 32'h2002, 32'h0000_BEEF, 0, 1,
         32'h5555_5555, 0, 0, 0, 0, 0, 1, 0, 32'h0);
    step("sh_c4", 1, 0, 0, 3'b001, 32'h2002, 0, 0, 0, 0,
         0, 0, 0, 0, 0, 0, 0, 32'h0);

    // LW: grant on the third cycle, rvalid two cycles later.
    for (int i = 0; i < 3; i++)
      step($sformatf("lw_c%0d", i), 1, 1, 0, 3'b010, 32'h3000, 0,
           (i == 2), 0, 0, 1, 0, 4'b0000, 32'h3000, 0, 1, 0, 32'h0);
    step("lw_c3", 1, 1, 0, 3'b010, 32'h3000, 0, 0, 0, 0,
         0, 0, 0, 0, 0, 1, 0, 32'h0);
    step("lw_c4", 1, 1, 0, 3'b010, 32'h3000, 0, 0, 1, 32'h1234_5678,
         0, 0, 0, 0, 0, 1, 0, 32'h0);
    // rvalid in DONE and IDLE must not disturb anything.
    step("lw_c5", 1, 0, 0, 3'b010, 32'h3000, 0, 0, 1, 32'hFFFF_FFFF,
         0, 0, 0, 0, 0, 0, 0, 32'h1234_5678);
    idle("lw_idle", 1, 32'hFFFF_FFFF);

    load("lbu", 0, 3'b100, 32'h0002, 32'h00F0_0000,
         32'h0000, 32'h0000_00F0);
    load("lh", 0, 3'b001, 32'h0002, 32'h9ABC_0000,
         32'h0000, 32'hFFFF_9ABC);
    load("lb_rw", 1, 3'b000, 32'h0000, 32'h0000_007F,
         32'h0000, 32'h0000_007F);
    load("lw_rsv", 0, 3'b011, 32'h0010, 32'hCAFE_F00D,
         32'h0010, 32'hCAFE_F00D);
    store("sb", 3'b000, 32'h0005, 32'h0000_00A5,
          32'h0004, 32'hA5A5_A5A5, 4'b0010);
    store("sw", 3'b010, 32'h0008, 32'h1122_3344,
          32'h0008, 32'h1122_3344, 4'b1111);

`ifdef MISALIGN_TRAP_EN
    step("lhu_mis", 1, 1, 0, 3'b101, 32'h0001, 0, 1, 0, 0,
         0, 0, 0, 0, 0, 0, 1, 32'h0);
    idle("lhu_idle", 0, 0);
`else
    load("lhu_al", 0, 3'b101, 32'h0001, 32'hABCD_8765,
         32'h0000, 32'h0000_8765);
`endif

    // Reset during WAIT_RESP abandons the access; late rvalid dropped.
    step("rm_c0", 1, 1, 0, 3'b001, 32'h0002, 0, 1, 0, 0,
         1, 0, 4'b0000, 32'h0000, 0, 1, 0, 32'h0);
    step("rm_c1", 1, 1, 0, 3'b001, 32'h0002, 0, 0, 0, 0,
         0, 0, 0, 0, 0, 1, 0, 32'h0);
    step("rm_rst", 0, 1, 0, 3'b001, 32'h0002, 0, 0, 0, 0,
         0, 0, 0, 0, 0, 0, 0, 32'h0);
    idle("rm_late", 1, 32'hFFFF_1234);
    idle("rm_after", 0, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() == 0) passes++;
    else $display("FAIL drain actual=%0d required=0", sb.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
